data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64; number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYC, default 2; wait cycles between accept and response (0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'd1024; byte address of word 0.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request faulted.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready=1; req_valid=1 on a clock edge accepts the request, latching we/addr/wdata.
REQ-017 On accept: go to WAIT with counter=WAIT_CYC-1 if WAIT_CYC>0; else go directly to RESP.
REQ-018 WAIT: req_ready=0; counter decrements each cycle; leaves for RESP on the edge where counter==0.
REQ-019 Store SHALL commit to the array on the edge entering RESP, never earlier; faulted stores SHALL NOT commit.
REQ-020 Load data SHALL be sampled from the array on the edge entering RESP and held stable in RESP.
REQ-021 RESP: rsp_valid=1, req_ready=0; rsp_valid, rsp_rdata, and rsp_err SHALL hold until rsp_ready=1 on an edge, then return to IDLE.
REQ-022 Accept-to-rsp_valid latency SHALL be WAIT_CYC+1 cycles; minimum request period SHALL be WAIT_CYC+2 cycles with rsp_ready held high.
REQ-023 A new request SHALL NOT be accepted on the same edge a response is consumed; req_ready rises the cycle after.
REQ-024 Word index SHALL be (req_addr - BASE_ADDR) >> 2, using 32-bit unsigned wrap-around subtraction.
REQ-025 req_valid asserted outside IDLE SHALL be ignored; initiator holds it until req_ready.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, and latched request fields 0; req_ready is 1 while in IDLE.
REQ-027 rst SHALL clear every array word to 0.
REQ-028 rst during WAIT or RESP SHALL abort the transaction; a pending store SHALL NOT commit.

Configuration
REQ-029 Macro DMEM_ERR_EN defined: rsp_err=1 when req_addr[1:0]!=0, or when the word index >= DEPTH; faulted loads return 0.
REQ-030 Macro DMEM_ERR_EN undefined: rsp_err tied 0; req_addr[1:0] ignored; index taken modulo DEPTH (wrap); all requests commit or read normally.

Structure
REQ-031 Package dmem_pkg SHALL hold the FSM state enum, the default BASE_ADDR constant, and the counter width constant (4).
REQ-032 Sub-module dmem_addr_decode (combinational) SHALL compute the word index and the error flag; the FSM and array stay in data_mem_responder.

Verification
REQ-033 Store 0xDEADBEEF to 1028, then load 1028 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after each accept (WAIT_CYC=2).
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable all 5 cycles; req_ready=0; IDLE the cycle after rsp_ready=1.
REQ-035 DMEM_ERR_EN defined: load 1026 -> rsp_err=1, rdata=0; store to 1024+4*64 -> rsp_err=1 and word 0 unchanged.
REQ-036 DMEM_ERR_EN undefined: store 0x12345678 to 1024+4*64 -> subsequent load 1024 returns 0x12345678, rsp_err=0.
REQ-037 Assert rst during WAIT of a store of 0xA5A5A5A5 to 1032 -> outputs reset immediately; later load 1032 returns 0.
REQ-038 WAIT_CYC=0, rsp_ready held 1, back-to-back loads -> one accept every 2 cycles, latency 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          CNT_W             = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between initiator and data memory
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_addr_decode.sv
// rtl/dmem_addr_decode.sv - byte address to word index and fault flag (DMEM_ERR_EN enables faults)
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          IDX_W     = 6,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic [31:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             err
);

  logic [31:0] offset;
  logic [31:0] word;
  logic        unused_lsb;

  // Wrap-around subtraction keeps addresses below the base mapping to huge indices.
  assign offset     = addr - BASE_ADDR;
  assign word       = {2'b00, offset[31:2]};
  assign unused_lsb = ^offset[1:0];

`ifdef DMEM_ERR_EN
  assign err = (addr[1:0] != 2'b00) || (word >= 32'(DEPTH));
  assign idx = word[IDX_W-1:0];
`else
  assign err = 1'b0;
  assign idx = IDX_W'(word % 32'(DEPTH));
`endif

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word memory answering one request at a time after a fixed wait (DMEM_ERR_EN enables faults)
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          WAIT_CYC  = 2,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             enter_resp;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [IDX_W-1:0] idx;
  logic             addr_err;

  // With no wait cycles RESP is entered on the accept edge, so use the live request then.
  assign accept    = (state == ST_IDLE) && bus.req_valid;
  assign cur_we    = (state == ST_IDLE) ? bus.req_we    : lat_we;
  assign cur_addr  = (state == ST_IDLE) ? bus.req_addr  : lat_addr;
  assign cur_wdata = (state == ST_IDLE) ? bus.req_wdata : lat_wdata;

  dmem_addr_decode #(
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr (cur_addr),
    .idx  (idx),
    .err  (addr_err)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state: IDLE -> (WAIT) -> RESP -> IDLE; requests outside IDLE are ignored.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (bus.req_valid) state_n = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == '0) state_n = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign enter_resp    = (state != ST_RESP) && (state_n == ST_RESP);
  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Latch the request and load the wait counter on accept; count down while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      lat_we    <= bus.req_we;
      lat_addr  <= bus.req_addr;
      lat_wdata <= bus.req_wdata;
    end else if (state == ST_WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Array: cleared by reset, store commits only on the edge entering RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && cur_we && !addr_err) begin
      mem[idx] <= cur_wdata;
    end
  end

  // Response data and fault captured on entering RESP and held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= addr_err;
      rdata_q <= (cur_we || addr_err) ? 32'd0 : mem[idx];
    end
  end

endmodule
